// File: rtl/pdm_sample_sequencer.sv
// pdm_sample_sequencer: steps the PDM buffer address at a programmable rate and registers the selected word.
// Define PDM_SEQ_ONESHOT_EN to add oneshot_i, which makes a run stop in ARMED after one pass.
module pdm_sample_sequencer #(
  parameter int PDM_BUFFER_WIDTH        = 128,
  parameter int PDM_DATA_WIDTH          = 64,
  parameter int PDM_BUFFER_ADRESS_WIDTH = 7,
  parameter int DIVIDER_WIDTH           = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable_i,
  input  logic                               trigger_i,
`ifdef PDM_SEQ_ONESHOT_EN
  input  logic                               oneshot_i,
`endif
  input  logic [DIVIDER_WIDTH-1:0]           step_div_i,
  input  logic [PDM_BUFFER_ADRESS_WIDTH:0]   seq_length_i,
  output logic [PDM_BUFFER_ADRESS_WIDTH-1:0] sample_select_o,
  input  logic [PDM_DATA_WIDTH-1:0]          pdm_data_in_i,
  output logic [PDM_DATA_WIDTH-1:0]          pdm_data_out_o,
  output logic                               pdm_valid_o,
  output logic                               running_o,
  output logic                               wrap_o
);
  localparam int AW = PDM_BUFFER_ADRESS_WIDTH;
  localparam int DW = DIVIDER_WIDTH;
  localparam logic [AW:0] LEN_MAX = (AW+1)'(PDM_BUFFER_WIDTH);
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  state_t state_q, state_d;
  logic trig_q;
  logic [DW-1:0] sd_q, sd_d, div_q, div_d, sd_clamp;
  logic [AW:0] len_q, len_d, len_clamp;
  logic [AW-1:0] sel_q, sel_d;
  logic [PDM_DATA_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, wrap_q, wrap_d, oneshot_q;
  logic trig_edge, start, run, step, last;
  assign trig_edge = trigger_i & ~trig_q;
  assign start     = enable_i && state_q == ARMED && trig_edge;
  assign run       = enable_i && state_q == RUN;
  assign step      = div_q == sd_q - DW'(1);
  assign last      = {1'b0, sel_q} == len_q - (AW+1)'(1);
  assign sd_clamp  = step_div_i == '0 ? DW'(1) : step_div_i;
  assign len_clamp = (seq_length_i == '0 || seq_length_i > LEN_MAX) ? LEN_MAX : seq_length_i;
`ifdef PDM_SEQ_ONESHOT_EN
  always_ff @(posedge clk)
    if (rst) oneshot_q <= 1'b0;
    else if (start) oneshot_q <= oneshot_i;
`else
  assign oneshot_q = 1'b0;
`endif
  // Disabling wins over everything, so an abort clears address/divider with no final capture.
  always_comb begin
    state_d = !enable_i ? IDLE
            : state_q == IDLE ? ARMED
            : start ? RUN
            : (run && step && last && oneshot_q) ? ARMED
            : state_q;
    sd_d    = start ? sd_clamp : sd_q;
    len_d   = start ? len_clamp : len_q;
    div_d   = run ? (step ? '0 : div_q + DW'(1)) : '0;
    sel_d   = !run ? '0 : !step ? sel_q : last ? '0 : sel_q + AW'(1);
    data_d  = (run && div_q == '0) ? pdm_data_in_i : data_q;
    valid_d = run && div_q == '0;
    wrap_d  = run && step && last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      trig_q  <= 1'b1;
      sd_q    <= DW'(1);
      len_q   <= LEN_MAX;
      div_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trigger_i;
      sd_q    <= sd_d;
      len_q   <= len_d;
      div_q   <= div_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end
  assign sample_select_o = sel_q;
  assign pdm_data_out_o  = data_q;
  assign pdm_valid_o     = valid_q;
  assign wrap_o          = wrap_q;
  assign running_o       = state_q == RUN;
endmodule

// File: tb/tb_pdm_sample_sequencer.sv
// tb_pdm_sample_sequencer: directed tests for the PDM sample sequencer; buffer model word[i] = i.
module tb_pdm_sample_sequencer;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, trigger = 1'b0, oneshot = 1'b0;
  logic [31:0] step_div = 32'd1;
  logic [7:0] seq_length = 8'd0;
  logic [6:0] sample_select;
  logic [63:0] pdm_data_in, pdm_data_out;
  logic pdm_valid, running, wrap;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign pdm_data_in = 64'(sample_select);
  pdm_sample_sequencer dut (
    .clk(clk), .rst(rst), .enable_i(enable), .trigger_i(trigger),
`ifdef PDM_SEQ_ONESHOT_EN
    .oneshot_i(oneshot),
`endif
    .step_div_i(step_div), .seq_length_i(seq_length), .sample_select_o(sample_select),
    .pdm_data_in_i(pdm_data_in), .pdm_data_out_o(pdm_data_out), .pdm_valid_o(pdm_valid),
    .running_o(running), .wrap_o(wrap)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic stop;
    enable = 1'b0;
    tick();
  endtask
  task automatic start_run(input logic [31:0] sd, input logic [7:0] len);
    step_div = sd;
    seq_length = len;
    enable = 1'b1;
    trigger = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
  endtask
  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; trigger = 1'b1;
    repeat (3) tick();
    checks++; if (sample_select !== 7'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sample_select); end
    checks++; if (pdm_data_out !== 64'd0) begin errors++; $display("FAIL reset_data got=%0h exp=0", pdm_data_out); end
    checks++; if (pdm_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", pdm_valid); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL held_trigger_no_start c=%0d got=%b exp=0", c, running); end
    end
    trigger = 1'b0; tick();
    trigger = 1'b1; tick();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL retrigger_start got=%b exp=1", running); end
    stop();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL disable_idle got=%b exp=0", running); end
  endtask
  task automatic test_full_rate;
    stop();
    start_run(32'd1, 8'd0);
    checks++; if (running !== 1'b1 || sample_select !== 7'd0 || pdm_valid !== 1'b0) begin errors++; $display("FAIL full_entry got run=%b sel=%0d v=%b exp 1/0/0", running, sample_select, pdm_valid); end
    for (int c = 0; c < 131; c++) begin
      tick();
      checks++; if (pdm_valid !== 1'b1) begin errors++; $display("FAIL full_valid c=%0d got=%b exp=1", c, pdm_valid); end
      checks++; if (pdm_data_out !== 64'(c % 128)) begin errors++; $display("FAIL full_data c=%0d got=%0d exp=%0d", c, pdm_data_out, c % 128); end
      checks++; if (sample_select !== 7'((c + 1) % 128)) begin errors++; $display("FAIL full_sel c=%0d got=%0d exp=%0d", c, sample_select, (c + 1) % 128); end
      checks++; if (wrap !== (c == 127)) begin errors++; $display("FAIL full_wrap c=%0d got=%b exp=%b", c, wrap, c == 127); end
    end
  endtask
  task automatic test_divided;
    stop();
    start_run(32'd4, 8'd3);
    for (int c = 0; c < 24; c++) begin
      tick();
      checks++; if (pdm_valid !== (c % 4 == 0)) begin errors++; $display("FAIL div_valid c=%0d got=%b exp=%b", c, pdm_valid, c % 4 == 0); end
      checks++; if (pdm_data_out !== 64'((c / 4) % 3)) begin errors++; $display("FAIL div_data c=%0d got=%0d exp=%0d", c, pdm_data_out, (c / 4) % 3); end
      checks++; if (sample_select !== 7'(((c + 1) / 4) % 3)) begin errors++; $display("FAIL div_sel c=%0d got=%0d exp=%0d", c, sample_select, ((c + 1) / 4) % 3); end
      checks++; if (wrap !== (c % 12 == 11)) begin errors++; $display("FAIL div_wrap c=%0d got=%b exp=%b", c, wrap, c % 12 == 11); end
    end
  endtask
  task automatic test_latch;
    stop();
    start_run(32'd4, 8'd0);
    for (int c = 0; c < 12; c++) begin
      if (c == 2) begin step_div = 32'd2; seq_length = 8'd1; end
      tick();
      checks++; if (pdm_valid !== (c % 4 == 0)) begin errors++; $display("FAIL latch_old_valid c=%0d got=%b exp=%b", c, pdm_valid, c % 4 == 0); end
      checks++; if (sample_select !== 7'((c + 1) / 4)) begin errors++; $display("FAIL latch_old_sel c=%0d got=%0d exp=%0d", c, sample_select, (c + 1) / 4); end
    end
    stop();
    start_run(32'd2, 8'd0);
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (pdm_valid !== (c % 2 == 0)) begin errors++; $display("FAIL latch_new_valid c=%0d got=%b exp=%b", c, pdm_valid, c % 2 == 0); end
      checks++; if (sample_select !== 7'((c + 1) / 2)) begin errors++; $display("FAIL latch_new_sel c=%0d got=%0d exp=%0d", c, sample_select, (c + 1) / 2); end
    end
  endtask
  task automatic test_len_one;
    stop();
    start_run(32'd3, 8'd1);
    for (int c = 0; c < 9; c++) begin
      tick();
      checks++; if (sample_select !== 7'd0) begin errors++; $display("FAIL len1_sel c=%0d got=%0d exp=0", c, sample_select); end
      checks++; if (wrap !== (c % 3 == 2)) begin errors++; $display("FAIL len1_wrap c=%0d got=%b exp=%b", c, wrap, c % 3 == 2); end
      checks++; if (pdm_valid !== (c % 3 == 0)) begin errors++; $display("FAIL len1_valid c=%0d got=%b exp=%b", c, pdm_valid, c % 3 == 0); end
    end
  endtask
  task automatic test_clamp;
    stop();
    start_run(32'd0, 8'd200);
    for (int c = 0; c < 130; c++) begin
      tick();
      checks++; if (pdm_valid !== 1'b1) begin errors++; $display("FAIL clamp_valid c=%0d got=%b exp=1", c, pdm_valid); end
      checks++; if (wrap !== (c == 127)) begin errors++; $display("FAIL clamp_wrap c=%0d got=%b exp=%b", c, wrap, c == 127); end
    end
    checks++; if (sample_select !== 7'd2) begin errors++; $display("FAIL clamp_sel got=%0d exp=2", sample_select); end
  endtask
  task automatic test_abort;
    stop();
    start_run(32'd1, 8'd0);
    trigger = 1'b0;
    repeat (5) tick();
    checks++; if (sample_select !== 7'd5 || pdm_data_out !== 64'd4) begin errors++; $display("FAIL abort_pre got sel=%0d data=%0d exp 5/4", sample_select, pdm_data_out); end
    enable = 1'b0; trigger = 1'b1;
    tick();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL abort_running got=%b exp=0", running); end
    checks++; if (sample_select !== 7'd0) begin errors++; $display("FAIL abort_sel got=%0d exp=0", sample_select); end
    checks++; if (pdm_data_out !== 64'd4) begin errors++; $display("FAIL abort_data got=%0d exp=4", pdm_data_out); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (pdm_valid !== 1'b0 || wrap !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL abort_quiet c=%0d got v=%b w=%b r=%b exp 0/0/0", c, pdm_valid, wrap, running); end
      tick();
    end
  endtask
`ifdef PDM_SEQ_ONESHOT_EN
  task automatic test_oneshot;
    int nvalid;
    stop();
    oneshot = 1'b1;
    for (int r = 0; r < 2; r++) begin
      nvalid = 0;
      start_run(32'd2, 8'd4);
      for (int c = 0; c < 12; c++) begin
        tick();
        if (pdm_valid === 1'b1) nvalid++;
        checks++; if (pdm_valid !== (c < 8 && c % 2 == 0)) begin errors++; $display("FAIL os_valid r=%0d c=%0d got=%b", r, c, pdm_valid); end
        checks++; if (wrap !== (c == 7)) begin errors++; $display("FAIL os_wrap r=%0d c=%0d got=%b exp=%b", r, c, wrap, c == 7); end
        checks++; if (running !== (c < 7)) begin errors++; $display("FAIL os_running r=%0d c=%0d got=%b exp=%b", r, c, running, c < 7); end
        if (c < 8) begin checks++; if (pdm_data_out !== 64'(c / 2)) begin errors++; $display("FAIL os_data r=%0d c=%0d got=%0d exp=%0d", r, c, pdm_data_out, c / 2); end end
      end
      checks++; if (nvalid != 4 || sample_select !== 7'd0) begin errors++; $display("FAIL os_count r=%0d got valids=%0d sel=%0d exp 4/0", r, nvalid, sample_select); end
    end
    oneshot = 1'b0;
  endtask
`endif
  initial begin
    test_reset();
    test_full_rate();
    test_divided();
    test_latch();
    test_len_one();
    test_clamp();
    test_abort();
`ifdef PDM_SEQ_ONESHOT_EN
    test_oneshot();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
